// File: rtl/gt_frame_rx.sv
// Receive-side deframer: finds {MAGIC,LEN} headers in the GT word stream, forwards LEN payload words with tlast, checks the XOR checksum.
// Latency: payload beat at cycle n appears on m_* at n+1; status pulses one cycle after the deciding beat or timeout hit.
// Backpressure: s_tready follows the output register only while forwarding payload; header/checksum/hunt words are always accepted.
module gt_frame_rx #(
    parameter logic [15:0] MAGIC   = 16'hA55A,
    parameter int          MAX_LEN = 256,
    parameter int          TIMEOUT = 1024
) (
    input  logic        core_clk,
    input  logic        reset,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        frame_ok,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt,
    output logic [15:0] drop_cnt
);

    localparam logic [1:0] ST_HUNT    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;

    localparam logic [1:0] ERR_LEN = 2'b01;
    localparam logic [1:0] ERR_SUM = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    // The idle counter only needs to reach TIMEOUT-1; the hit is detected on the idle cycle that would make it TIMEOUT.
    localparam int               IW        = $clog2(TIMEOUT);
    localparam logic [IW-1:0]    IDLE_LAST = IW'(TIMEOUT - 1);
    localparam logic [31:0]      MAX_LEN_W = MAX_LEN;

    logic [1:0]    r_state;
    logic [15:0]   r_rem;
    logic [31:0]   r_acc;
    logic [IW-1:0] r_idle;

    logic        w_beat;
    logic [15:0] w_len;
    logic        w_is_magic;
    logic        w_len_ok;
    logic        w_start;
    logic        w_in_frame;
    logic        w_timeout;
    logic        w_ok_evt;
    logic        w_err_evt;
    logic [1:0]  w_err_code;
    logic        w_drop_evt;

    assign w_beat     = s_tvalid & s_tready;
    assign w_len      = s_tdata[15:0];
    assign w_is_magic = (s_tdata[31:16] == MAGIC);
    assign w_len_ok   = (w_len != 16'd0) && ({16'd0, w_len} <= MAX_LEN_W);
    assign w_in_frame = (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
    assign w_start    = (r_state == ST_HUNT) && w_beat && w_is_magic && w_len_ok;
    // Only truly idle cycles count; a stalled valid word is the downstream's fault, not the link's.
    assign w_timeout  = w_in_frame && !s_tvalid && (r_idle == IDLE_LAST);

    // Input accept: held low in reset, gated by the output register only while payload is flowing.
    always_comb begin
        s_tready = 1'b0;
        if (!reset) begin
            if (r_state == ST_PAYLOAD) s_tready = !m_tvalid || m_tready;
            else                       s_tready = 1'b1;
        end
    end

    // Per-cycle decision: which status event (if any) this cycle produces.
    always_comb begin
        w_ok_evt   = 1'b0;
        w_err_evt  = 1'b0;
        w_err_code = ERR_LEN;
        w_drop_evt = 1'b0;
        if (r_state == ST_HUNT && w_beat) begin
            if (!w_is_magic) begin
                w_drop_evt = 1'b1;
            end else if (!w_len_ok) begin
                w_err_evt  = 1'b1;
                w_err_code = ERR_LEN;
            end
        end else if (r_state == ST_CHECK && w_beat) begin
            if (s_tdata == r_acc) begin
                w_ok_evt = 1'b1;
            end else begin
                w_err_evt  = 1'b1;
                w_err_code = ERR_SUM;
            end
        end else if (w_timeout) begin
            w_err_evt  = 1'b1;
            w_err_code = ERR_TMO;
        end
    end

    // Frame state machine with remaining-count, checksum accumulator and idle timer.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            r_state <= ST_HUNT;
            r_rem   <= 16'd0;
            r_acc   <= 32'd0;
            r_idle  <= '0;
        end else begin
            case (r_state)
                ST_HUNT: begin
                    if (w_start) begin
                        r_state <= ST_PAYLOAD;
                        r_rem   <= w_len;
                        r_acc   <= 32'd0;
                        r_idle  <= '0;
                    end
                end
                ST_PAYLOAD, ST_CHECK: begin
                    if (w_beat) begin
                        r_idle <= '0;
                        if (r_state == ST_PAYLOAD) begin
                            r_acc <= r_acc ^ s_tdata;
                            r_rem <= r_rem - 16'd1;
                            if (r_rem == 16'd1) r_state <= ST_CHECK;
                        end else begin
                            r_state <= ST_HUNT;
                        end
                    end else if (w_timeout) begin
                        r_idle  <= '0;
                        r_state <= ST_HUNT;
                    end else if (!s_tvalid) begin
                        r_idle <= r_idle + IW'(1);
                    end
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end

    // Output register: loads on payload beats, drains on m_tready regardless of frame state.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            m_tdata  <= 32'd0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else if (r_state == ST_PAYLOAD && w_beat) begin
            m_tdata  <= s_tdata;
            m_tvalid <= 1'b1;
            m_tlast  <= (r_rem == 16'd1);
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

    // Status pulses and sticky error code.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            err_code  <= 2'b00;
        end else begin
            frame_ok  <= w_ok_evt;
            frame_err <= w_err_evt;
            if (w_err_evt) err_code <= w_err_code;
        end
    end

    // Saturating statistics, updated on the same edge that raises the matching pulse.
    always_ff @(posedge core_clk) begin
        if (reset) begin
            ok_cnt   <= 16'd0;
            err_cnt  <= 16'd0;
            drop_cnt <= 16'd0;
        end else begin
            if (w_ok_evt   && ok_cnt   != 16'hFFFF) ok_cnt   <= ok_cnt   + 16'd1;
            if (w_err_evt  && err_cnt  != 16'hFFFF) err_cnt  <= err_cnt  + 16'd1;
            if (w_drop_evt && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_gt_frame_rx.sv
// Bench for gt_frame_rx: randomized frames against a stream-level frame model.
// Inputs driven 1ns after rising edge, outputs sampled on the falling edge.
// Downstream ready patterns: always, random, 1-0-0-1, forced stall.
module tb_gt_frame_rx;

    localparam logic [15:0] MAGIC   = 16'hA55A;
    localparam int          MAX_LEN = 256;
    localparam int          TIMEOUT = 1024;

    logic        core_clk = 1'b0;
    logic        reset;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic        frame_ok;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [15:0] ok_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    gt_frame_rx #(.MAGIC(MAGIC), .MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .core_clk (core_clk), .reset   (reset),
        .s_tdata  (s_tdata),  .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata  (m_tdata),  .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .frame_ok (frame_ok), .frame_err(frame_err), .err_code(err_code),
        .ok_cnt   (ok_cnt),   .err_cnt (err_cnt),  .drop_cnt(drop_cnt)
    );

    always #5 core_clk = ~core_clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] stim[$];
    logic [32:0] got_beats[$];
    logic [32:0] exp_beats[$];
    logic [1:0]  got_ev[$];      // 0 = frame_ok, otherwise the err_code seen with frame_err
    logic [1:0]  exp_ev[$];
    int exp_ok, exp_err, exp_drop;
    int rdy_mode  = 0;           // 0 always, 1 random, 2 pattern 1,0,0,1, 3 forced low
    int rdy_phase = 0;

    // Downstream ready generator.
    always @(posedge core_clk) begin
        #1;
        case (rdy_mode)
            0: m_tready = 1'b1;
            1: m_tready = 1'($urandom_range(0, 1));
            2: begin
                m_tready  = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                rdy_phase = rdy_phase + 1;
            end
            default: m_tready = 1'b0;
        endcase
    end

    // Monitor: record accepted output beats and status pulses.
    always @(negedge core_clk) begin
        if (!reset && m_tvalid && m_tready) got_beats.push_back({m_tlast, m_tdata});
        if (frame_ok)  got_ev.push_back(2'd0);
        if (frame_err) got_ev.push_back(err_code);
    end

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // Reference: interpret a word stream frame by frame from the wire format.
    function automatic void model(input logic [31:0] w[$]);
        int i = 0;
        int len;
        logic [31:0] cur, acc;
        while (i < w.size()) begin
            cur = w[i];
            if (cur[31:16] != MAGIC) begin
                exp_drop = sat(exp_drop);
                i++;
            end else begin
                len = int'(cur[15:0]);
                if (len == 0 || len > MAX_LEN) begin
                    exp_ev.push_back(2'd1);
                    exp_err = sat(exp_err);
                    i++;
                end else begin
                    acc = 32'd0;
                    for (int k = 1; k <= len; k++) begin
                        acc = acc ^ w[i + k];
                        exp_beats.push_back({k == len, w[i + k]});
                    end
                    if (w[i + len + 1] == acc) begin
                        exp_ev.push_back(2'd0);
                        exp_ok = sat(exp_ok);
                    end else begin
                        exp_ev.push_back(2'd2);
                        exp_err = sat(exp_err);
                    end
                    i += len + 2;
                end
            end
        end
    endfunction

    function automatic void add_frame(input int len, input bit corrupt);
        logic [31:0] d, acc;
        stim.push_back({MAGIC, 16'(len)});
        acc = 32'd0;
        for (int k = 0; k < len; k++) begin
            d = $urandom;
            stim.push_back(d);
            acc = acc ^ d;
        end
        stim.push_back(corrupt ? (acc ^ 32'h0000_0100) : acc);
    endfunction

    function automatic void add_junk();
        logic [31:0] d;
        d = $urandom;
        if (d[31:16] == MAGIC) d[31] = ~d[31];
        stim.push_back(d);
    endfunction

    function automatic bit beats_equal();
        if (got_beats.size() != exp_beats.size()) return 1'b0;
        foreach (got_beats[i]) if (got_beats[i] !== exp_beats[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ev_equal();
        if (got_ev.size() != exp_ev.size()) return 1'b0;
        foreach (got_ev[i]) if (got_ev[i] !== exp_ev[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void clear_all();
        stim.delete(); got_beats.delete(); exp_beats.delete(); got_ev.delete(); exp_ev.delete();
    endfunction

    // Present one word until accepted (bounded), leaving s_tvalid low afterwards.
    task automatic drive_word(input logic [31:0] w);
        bit done = 1'b0;
        int n = 0;
        s_tdata  = w;
        s_tvalid = 1'b1;
        while (!done) begin
            @(negedge core_clk);
            done = s_tready;
            @(posedge core_clk);
            #1;
            n++;
            if (!done && n > 5000) begin
                checks++; failures++;
                $display("FAIL drive_word accept timeout: word=%h not accepted in %0d cycles", w, n);
                done = 1'b1;
            end
        end
        s_tvalid = 1'b0;
    endtask

    task automatic send_stream(input int first, input int max_gap);
        for (int i = first; i < stim.size(); i++) begin
            repeat ($urandom_range(0, max_gap)) begin @(posedge core_clk); #1; end
            drive_word(stim[i]);
        end
    endtask

    task automatic drain();
        rdy_mode = 0;
        repeat (4) @(posedge core_clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0; rdy_mode = 0;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        checks++;
        if ({s_tready, m_tvalid, m_tlast, frame_ok, frame_err, err_code, ok_cnt, err_cnt, drop_cnt, m_tdata} !== '0) begin
            failures++;
            $display("FAIL reset.state got rdy=%b vld=%b last=%b ok=%b err=%b code=%b cnt=%h/%h/%h dat=%h required all zero",
                     s_tready, m_tvalid, m_tlast, frame_ok, frame_err, err_code, ok_cnt, err_cnt, drop_cnt, m_tdata);
        end
        @(posedge core_clk); #1;
        reset = 1'b0;
        exp_ok = 0; exp_err = 0; exp_drop = 0;
        @(negedge core_clk);
        checks++;
        if (s_tready !== 1'b1) begin failures++; $display("FAIL reset.ready_after got=%b required=1", s_tready); end
        @(posedge core_clk); #1;
        clear_all();
    endtask

    task automatic test_good_frame();
        clear_all();
        stim = '{32'hA55A0004, 32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
        model(stim);
        drive_word(stim[0]);
        checks++;
        if (m_tvalid !== 1'b0) begin failures++; $display("FAIL good.header_no_output got m_tvalid=%b required=0", m_tvalid); end
        drive_word(stim[1]);
        checks++;
        if ({m_tvalid, m_tdata} !== {1'b1, 32'd1}) begin
            failures++; $display("FAIL good.latency got vld=%b dat=%h required vld=1 dat=00000001", m_tvalid, m_tdata);
        end
        send_stream(2, 0);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL good.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL good.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (ok_cnt !== 16'd1) begin failures++; $display("FAIL good.ok_cnt got=%0d required=1", ok_cnt); end
        checks++; if (err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL good.err_cnt got=%0d required=%0d", err_cnt, exp_err); end
    endtask

    task automatic test_bad_checksum();
        clear_all();
        stim = '{32'hA55A0004, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
        model(stim);
        send_stream(0, 0);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL badsum.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL badsum.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (err_code !== 2'b10) begin failures++; $display("FAIL badsum.err_code got=%b required=10", err_code); end
        checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL badsum.err_cnt got=%0d required=1", err_cnt); end
    endtask

    task automatic test_drop();
        clear_all();
        stim = '{32'hDEADBEEF, 32'h12345678, 32'hA55A0001, 32'hCAFEF00D, 32'hCAFEF00D};
        model(stim);
        send_stream(0, 1);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL drop.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL drop.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (drop_cnt !== 16'd2) begin failures++; $display("FAIL drop.drop_cnt got=%0d required=2", drop_cnt); end
        checks++; if (ok_cnt !== 16'(exp_ok)) begin failures++; $display("FAIL drop.ok_cnt got=%0d required=%0d", ok_cnt, exp_ok); end
    endtask

    task automatic test_bad_len();
        clear_all();
        stim = '{32'hA55A0000, 32'hA55A0101};
        model(stim);
        send_stream(0, 0);
        drain();
        checks++; if (got_beats.size() != 0) begin failures++; $display("FAIL badlen.no_output got %0d beats required 0", got_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL badlen.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL badlen.err_cnt got=%0d required=%0d", err_cnt, exp_err); end
        // Still hunting: a following junk word must be counted as dropped.
        clear_all();
        add_junk();
        model(stim);
        send_stream(0, 0);
        drain();
        checks++; if (drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL badlen.still_hunt drop_cnt got=%0d required=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_back_to_back();
        time t0;
        clear_all();
        add_frame(3, 1'b0);
        add_frame(2, 1'b0);
        model(stim);
        t0 = $time;
        send_stream(0, 0);
        checks++;
        if (($time - t0) / 10 != 64'(stim.size())) begin
            failures++; $display("FAIL b2b.throughput got %0d cycles required %0d", ($time - t0) / 10, stim.size());
        end
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL b2b.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL b2b.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (ok_cnt !== 16'(exp_ok)) begin failures++; $display("FAIL b2b.ok_cnt got=%0d required=%0d", ok_cnt, exp_ok); end
    endtask

    task automatic test_random();
        clear_all();
        for (int f = 0; f < 12; f++) begin
            repeat ($urandom_range(0, 2)) add_junk();
            case ($urandom_range(0, 5))
                0:       stim.push_back({MAGIC, 16'd0});
                1:       stim.push_back({MAGIC, 16'(MAX_LEN + 1 + $urandom_range(0, 200))});
                default: add_frame($urandom_range(1, 12), $urandom_range(0, 3) == 0);
            endcase
        end
        model(stim);
        rdy_mode = 1;
        send_stream(0, 2);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL random.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL random.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (ok_cnt !== 16'(exp_ok)) begin failures++; $display("FAIL random.ok_cnt got=%0d required=%0d", ok_cnt, exp_ok); end
        checks++; if (err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL random.err_cnt got=%0d required=%0d", err_cnt, exp_err); end
        checks++; if (drop_cnt !== 16'(exp_drop)) begin failures++; $display("FAIL random.drop_cnt got=%0d required=%0d", drop_cnt, exp_drop); end
    endtask

    task automatic test_stall();
        clear_all();
        add_frame(8, 1'b0);
        model(stim);
        rdy_phase = 0;
        rdy_mode  = 2;
        for (int i = 0; i < 5; i++) drive_word(stim[i]);
        fork
            send_stream(5, 0);
            begin
                rdy_mode = 3;
                repeat (2000) @(posedge core_clk);
                rdy_mode = 2;
            end
        join
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL stall.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL stall.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL stall.err_cnt got=%0d required=%0d", err_cnt, exp_err); end
    endtask

    task automatic test_timeout();
        clear_all();
        rdy_mode = 0;
        drive_word({MAGIC, 16'd8});
        for (int k = 1; k <= 3; k++) begin
            drive_word(32'h0000_1000 + 32'(k));
            exp_beats.push_back({1'b0, 32'h0000_1000 + 32'(k)});
        end
        exp_ev.push_back(2'd3);
        exp_err = sat(exp_err);
        repeat (TIMEOUT - 1) @(posedge core_clk);
        @(negedge core_clk);
        checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL timeout.early got frame_err=%b required=0", frame_err); end
        @(posedge core_clk);
        @(negedge core_clk);
        checks++;
        if ({frame_err, err_code} !== {1'b1, 2'b11}) begin
            failures++; $display("FAIL timeout.pulse got err=%b code=%b required err=1 code=11", frame_err, err_code);
        end
        @(posedge core_clk); #1;
        // Back in HUNT: a fresh frame must be accepted.
        stim.delete();
        add_frame(1, 1'b0);
        model(stim);
        send_stream(0, 0);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL timeout.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL timeout.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (err_cnt !== 16'(exp_err)) begin failures++; $display("FAIL timeout.err_cnt got=%0d required=%0d", err_cnt, exp_err); end
    endtask

    task automatic test_reset_mid();
        clear_all();
        rdy_mode = 0;
        drive_word({MAGIC, 16'd4});
        drive_word(32'h11111111);
        drive_word(32'h22222222);
        reset = 1'b1;
        @(posedge core_clk);
        @(negedge core_clk);
        checks++; if (m_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid.tvalid got=%b required=0", m_tvalid); end
        repeat (2) @(posedge core_clk);
        #1;
        reset = 1'b0;
        exp_ok = 0; exp_err = 0; exp_drop = 0;
        @(posedge core_clk); #1;
        checks++; if (got_ev.size() != 0) begin failures++; $display("FAIL rstmid.no_pulse got %0d status pulses required 0", got_ev.size()); end
        checks++; if ({ok_cnt, err_cnt, drop_cnt} !== 48'd0) begin failures++; $display("FAIL rstmid.counters got %0d/%0d/%0d required 0/0/0", ok_cnt, err_cnt, drop_cnt); end
        clear_all();
        add_frame(2, 1'b0);
        model(stim);
        send_stream(0, 0);
        drain();
        checks++; if (!beats_equal()) begin failures++; $display("FAIL rstmid.beats got %0d beats required %0d (content differs)", got_beats.size(), exp_beats.size()); end
        checks++; if (!ev_equal()) begin failures++; $display("FAIL rstmid.events got %0d events required %0d (content differs)", got_ev.size(), exp_ev.size()); end
        checks++; if (ok_cnt !== 16'd1) begin failures++; $display("FAIL rstmid.ok_cnt got=%0d required=1", ok_cnt); end
    endtask

    initial begin
        reset = 1'b1; s_tvalid = 1'b0; s_tdata = 32'd0; m_tready = 1'b1;
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_drop();
        test_bad_len();
        test_back_to_back();
        test_random();
        test_stall();
        test_timeout();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
